// File: rtl/barrel_shifter.sv
// barrel_shifter: registered log-stage shifter, arithmetic right or logical left
module barrel_shifter #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             SH_DIR,
  input  logic [AMT_W-1:0] SH_AMT,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] D_OUT
);
  logic [WIDTH-1:0] w_rev_in;
  logic [WIDTH-1:0] w_rev_out;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_stage [AMT_W+1];
  logic             w_fill;
  logic [WIDTH-1:0] r_d_out;
  // Right shifts reuse the left-shift stages by reversing bits on the way in and out;
  // the fill bit is the sign for right shifts and zero for left shifts.
  assign w_fill     = SH_DIR & D_IN[WIDTH-1];
  assign w_stage[0] = SH_DIR ? w_rev_in : D_IN;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign w_rev_in[i]  = D_IN[WIDTH-1-i];
    assign w_rev_out[i] = w_stage[AMT_W][WIDTH-1-i];
  end
  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int S = 2 ** k;
    assign w_stage[k+1] = SH_AMT[k] ? {w_stage[k][WIDTH-1-S:0], {S{w_fill}}} : w_stage[k];
  end
  assign w_result = SH_DIR ? w_rev_out : w_stage[AMT_W];
  // Output register; reset wins over the shift sampled on the same edge
  always_ff @(posedge Clk) r_d_out <= Rst ? '0 : w_result;
  assign D_OUT = r_d_out;
endmodule

// File: tb/tb_barrel_shifter.sv
// tb_barrel_shifter: directed checks of reset, both shift directions, latency and mid-stream reset
module tb_barrel_shifter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sh_dir = 1'b0;
  logic [4:0]  sh_amt = '0;
  logic [31:0] d_in = '0;
  logic [31:0] d_out;
  logic [31:0] last_exp = '0;
  int          errors = 0;
  int          checks = 0;

  barrel_shifter #(.WIDTH(32), .AMT_W(5)) dut (
    .Clk(clk), .Rst(rst), .SH_DIR(sh_dir), .SH_AMT(sh_amt), .D_IN(d_in), .D_OUT(d_out)
  );

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic dir, input logic [4:0] amt,
                      input logic [31:0] din, input logic [31:0] exp, input string tag);
    @(negedge clk);
    rst = r; sh_dir = dir; sh_amt = amt; d_in = din;
    #1;
    checks++;
    assert (d_out === last_exp) else begin
      errors++;
      $error("FAIL %s_hold: D_OUT=%h expected %h", tag, d_out, last_exp);
    end
    @(posedge clk);
    #1;
    checks++;
    assert (d_out === exp) else begin
      errors++;
      $error("FAIL %s: D_OUT=%h expected %h", tag, d_out, exp);
    end
    last_exp = exp;
  endtask

  initial begin
    d_in = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0000, "reset1");
    step(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h0000_0000, "reset2");
    step(1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "reset_release");
    step(1'b0, 1'b1, 5'd0,  32'h8000_0000, 32'h8000_0000, "asr_neg0");
    step(1'b0, 1'b1, 5'd1,  32'h8000_0000, 32'hC000_0000, "asr_neg1");
    step(1'b0, 1'b1, 5'd4,  32'h8000_0000, 32'hF800_0000, "asr_neg4");
    step(1'b0, 1'b1, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, "asr_neg31");
    for (int n = 0; n < 32; n++)
      step(1'b0, 1'b1, n[4:0], 32'h8000_0000, ~(32'hFFFF_FFFF >> (n + 1)), "asr_neg_sweep");
    step(1'b0, 1'b1, 5'd0,  32'h4000_0000, 32'h4000_0000, "asr_pos0");
    step(1'b0, 1'b1, 5'd1,  32'h4000_0000, 32'h2000_0000, "asr_pos1");
    step(1'b0, 1'b1, 5'd30, 32'h4000_0000, 32'h0000_0001, "asr_pos30");
    step(1'b0, 1'b1, 5'd31, 32'h4000_0000, 32'h0000_0000, "asr_pos31");
    for (int n = 0; n < 32; n++)
      step(1'b0, 1'b1, n[4:0], 32'h4000_0000, 32'h4000_0000 >> n, "asr_pos_sweep");
    step(1'b0, 1'b1, 5'd3,  32'hA5A5_A5A5, 32'hF4B4_B4B4, "asr_mixed");
    for (int n = 0; n < 32; n++)
      step(1'b0, 1'b0, n[4:0], 32'h0000_0001, 32'h0000_0001 << n, "lsl_sweep");
    step(1'b0, 1'b0, 5'd31, 32'h0000_0001, 32'h8000_0000, "lsl31");
    step(1'b0, 1'b0, 5'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "lsl_no_lsb_fill");
    step(1'b0, 1'b0, 5'd16, 32'h8001_8001, 32'h8001_0000, "lsl_discard");
    step(1'b0, 1'b0, 5'd4,  32'h0000_000F, 32'h0000_00F0, "b2b_left");
    step(1'b0, 1'b1, 5'd8,  32'hF000_0000, 32'hFFF0_0000, "b2b_right");
    step(1'b0, 1'b0, 5'd4,  32'h0000_000F, 32'h0000_00F0, "mid_left");
    step(1'b1, 1'b1, 5'd8,  32'hF000_0000, 32'h0000_0000, "mid_reset");
    step(1'b0, 1'b0, 5'd1,  32'h0000_0003, 32'h0000_0006, "mid_after");
    step(1'b0, 1'b1, 5'd8,  32'hF000_0000, 32'hFFF0_0000, "mid_right");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- Single-cycle registered 32-bit barrel shifter for the datapath.
- Performs either an arithmetic right shift or a logical left shift of a data word by 0–31 positions.
- The result is registered on the rising clock edge.
- Used wherever the ALU or other datapath logic needs a variable-amount shift.

Parameters:
- WIDTH, 32, data word width in bits.
- AMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- SH_DIR  input  1  shift direction: 1 = arithmetic right, 0 = logical left.
- SH_AMT  input  AMT_W  shift amount, unsigned, 0..WIDTH-1.
- D_IN  input  WIDTH  operand to be shifted.
- D_OUT  output  WIDTH  registered shift result.

Behaviour:
- One clock domain (Clk). Reset is synchronous and active-high: on a rising edge with Rst=1, D_OUT <= 0. Rst has priority over any shift.
- Latency is exactly 1 cycle:
  - SH_DIR, SH_AMT and D_IN are sampled at rising edge N.
  - The result appears on D_OUT after edge N and holds until edge N+1.
  - There is no enable; D_OUT updates every cycle with no stall or handshake.
- Right shift (SH_DIR=1) is arithmetic:
  - D_OUT = D_IN >>> SH_AMT.
  - Vacated MSBs are filled with D_IN[WIDTH-1].
  - Negative operands therefore stay negative; positive operands fill with 0.
- Left shift (SH_DIR=0) is logical:
  - D_OUT = D_IN << SH_AMT.
  - Vacated LSBs are filled with 0; bits shifted past the MSB are discarded.
- Arithmetic and width rules:
  - SH_AMT=0 passes D_IN unchanged in both directions.
  - SH_AMT is treated as unsigned. The maximum shift is WIDTH-1, so no out-of-range case exists.
- Implementation structure:
  - Log-shifter of AMT_W mux stages: stage k shifts by 2^k when SH_AMT[k]=1.
  - The stages are combinational, followed by one output register.
  - The right and left paths may share stages via bit reversal, or be built separately; either is acceptable.
- Reset mid-operation: a shift sampled in the same cycle as Rst=1 is discarded and D_OUT = 0. The shift sampled on the next edge with Rst=0 is produced normally.
- No X propagation from the fill logic: the fill bit is always either D_IN[WIDTH-1] or 0.

Test Plan:
- Reset: drive Rst=1 for 2 edges with D_IN=0xFFFFFFFF, SH_AMT=0 -> D_OUT=0x00000000. Release Rst -> next edge gives D_OUT=0xFFFFFFFF.
- Arithmetic right, negative operand: D_IN=0x80000000, SH_DIR=1, sweep SH_AMT 0..31. Expected:
  - amt 0 -> 0x80000000
  - amt 1 -> 0xC0000000
  - amt 4 -> 0xF8000000
  - amt 31 -> 0xFFFFFFFF
  - in general, amt n -> the top n+1 bits set.
- Arithmetic right, positive operand: D_IN=0x40000000, SH_DIR=1, sweep SH_AMT 0..31. Expected:
  - amt 0 -> 0x40000000
  - amt 1 -> 0x20000000
  - amt 30 -> 0x00000001
  - amt 31 -> 0x00000000
- Logical left: D_IN=0x00000001, SH_DIR=0, sweep SH_AMT 0..31. Expected:
  - amt n -> 1<<n
  - amt 31 -> 0x80000000
  - no bit ever appears in bit 0 for amt>0.
- Latency and back-to-back: change inputs every cycle:
  - (left, 4, 0x0000000F) -> 0x000000F0
  - then (right, 8, 0xF0000000) -> 0xFFF00000
  - each result is visible exactly one edge after its inputs are sampled.
- Reset mid-stream: during the back-to-back sequence, assert Rst for one edge -> D_OUT=0 for that cycle only. The following edge shows the shift of the inputs sampled at that edge.
